// File: rtl/mem_access_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_access_sequencer_pkg
// Purpose : Shared definitions for the memory access sequencer. Holds the
//           sequencer state encoding, the memory-mapped I/O port addresses
//           (shared with data_memory_manager) and the wait-counter width.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package mem_access_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_WRITE = 3'd2,
    ST_READ  = 3'd3,
    ST_RESP  = 3'd4
  } seq_state_t;

  // Memory-mapped I/O ports decoded by data_memory_manager.
  localparam logic [9:0] INPUT_PORT_ADDR  = 10'h3FE;
  localparam logic [9:0] OUTPUT_PORT_ADDR = 10'h3FF;

  // READ_WAIT is limited to 0..7, so three bits hold the countdown.
  localparam int WAIT_CNT_W = 3;

endpackage : mem_access_sequencer_pkg
`default_nettype wire

// File: rtl/mem_access_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module  : mem_access_sequencer_if
// Purpose : Bundles the request, response and manager-bus signals of the
//           memory access sequencer.
// Ports   : request  in_req_valid/out_req_ready/in_req_write/in_req_addr/
//                    in_req_data
//           response out_resp_valid/in_resp_ready/out_resp_data/out_resp_err
//           manager  out_mem_addr/out_mem_addr_write_en/out_mem_write_en/
//                    out_mem_read_en/out_mem_data/in_mem_data
//           Modport slave is the sequencer view, master the environment view.
// Revision: 1.0 - initial release
// ============================================================================
interface mem_access_sequencer_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
);
  logic              in_req_valid;
  logic              out_req_ready;
  logic              in_req_write;
  logic [ADDR_W-1:0] in_req_addr;
  logic [DATA_W-1:0] in_req_data;
  logic              out_resp_valid;
  logic              in_resp_ready;
  logic [DATA_W-1:0] out_resp_data;
  logic              out_resp_err;
  logic [ADDR_W-1:0] out_mem_addr;
  logic              out_mem_addr_write_en;
  logic              out_mem_write_en;
  logic              out_mem_read_en;
  logic [DATA_W-1:0] out_mem_data;
  logic [DATA_W-1:0] in_mem_data;

  modport slave (
    input  in_req_valid, in_req_write, in_req_addr, in_req_data,
           in_resp_ready, in_mem_data,
    output out_req_ready, out_resp_valid, out_resp_data, out_resp_err,
           out_mem_addr, out_mem_addr_write_en, out_mem_write_en,
           out_mem_read_en, out_mem_data
  );

  modport master (
    output in_req_valid, in_req_write, in_req_addr, in_req_data,
           in_resp_ready, in_mem_data,
    input  out_req_ready, out_resp_valid, out_resp_data, out_resp_err,
           out_mem_addr, out_mem_addr_write_en, out_mem_write_en,
           out_mem_read_en, out_mem_data
  );
endinterface : mem_access_sequencer_if
`default_nettype wire

// File: rtl/mem_access_sequencer_port_addr_guard.sv
`default_nettype none
// ============================================================================
// Module  : mem_access_sequencer_port_addr_guard
// Purpose : Combinational check that rejects accesses going the wrong way on
//           a memory-mapped port: a store to the input port or a load from
//           the output port.
// Ports   : addr   in  ADDR_W  request address
//           write  in  1       1=store, 0=load
//           reject out 1       access must not be sequenced
// Revision: 1.0 - initial release
// ============================================================================
module mem_access_sequencer_port_addr_guard
  import mem_access_sequencer_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  wire logic [ADDR_W-1:0] addr,
  input  wire logic              write,
  output logic                   reject
);

  assign reject = (write  && (addr == ADDR_W'(INPUT_PORT_ADDR))) ||
                  (!write && (addr == ADDR_W'(OUTPUT_PORT_ADDR)));

endmodule : mem_access_sequencer_port_addr_guard
`default_nettype wire

// File: rtl/mem_access_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : mem_access_sequencer
// Purpose : Upstream driver of data_memory_manager. Accepts one load/store
//           request at a time and sequences the manager's address-latch,
//           write and read strobes, then returns a response.
// Ports   : clk    in  1  single clock
//           rst_n  in  1  asynchronous active-low reset
//           bus    mem_access_sequencer_if.slave (request/response/manager)
// Macro   : PORT_ADDR_GUARD_EN - when defined, a store to the input port or a
//           load from the output port is answered with resp_err=1 and no
//           manager strobe; otherwise every address is sequenced and
//           out_resp_err is tied low.
// Revision: 1.0 - initial release
// ============================================================================
module mem_access_sequencer
  import mem_access_sequencer_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 8,
  parameter int READ_WAIT = 1   // extra read-strobe cycles, 0..7
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  mem_access_sequencer_if.slave bus
);

  seq_state_t            r_state;
  logic [WAIT_CNT_W-1:0] r_wait_cnt;
  logic                  r_req_write;
  logic                  r_req_ready;
  logic                  r_resp_valid;
  logic [DATA_W-1:0]     r_resp_data;
  logic [ADDR_W-1:0]     r_mem_addr;
  logic [DATA_W-1:0]     r_mem_data;
  logic                  r_addr_we;
  logic                  r_write_en;
  logic                  r_read_en;
  logic                  w_reject;

`ifdef PORT_ADDR_GUARD_EN
  logic r_resp_err;

  mem_access_sequencer_port_addr_guard #(
    .ADDR_W (ADDR_W)
  ) u_port_addr_guard (
    .addr   (bus.in_req_addr),
    .write  (bus.in_req_write),
    .reject (w_reject)
  );

  assign bus.out_resp_err = r_resp_err;
`else
  assign w_reject         = 1'b0;
  assign bus.out_resp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_wait_cnt   <= '0;
      r_req_write  <= 1'b0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
      r_mem_addr   <= '0;
      r_mem_data   <= '0;
      r_addr_we    <= 1'b0;
      r_write_en   <= 1'b0;
      r_read_en    <= 1'b0;
`ifdef PORT_ADDR_GUARD_EN
      r_resp_err   <= 1'b0;
`endif
    end else begin
      // Strobes are single-cycle pulses unless a state re-asserts them,
      // which keeps them one-hot by construction.
      r_addr_we  <= 1'b0;
      r_write_en <= 1'b0;
      r_read_en  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.in_req_valid) begin
            r_req_ready <= 1'b0;
            r_resp_data <= '0;
            if (w_reject) begin
              // Manager bus is left untouched on a rejected access.
              r_resp_valid <= 1'b1;
              r_state      <= ST_RESP;
            end else begin
              r_req_write <= bus.in_req_write;
              r_mem_addr  <= bus.in_req_addr;
              r_mem_data  <= bus.in_req_data;
              r_addr_we   <= 1'b1;
              r_state     <= ST_ADDR;
            end
`ifdef PORT_ADDR_GUARD_EN
            r_resp_err <= w_reject;
`endif
          end
        end
        ST_ADDR: begin
          if (r_req_write) begin
            r_write_en <= 1'b1;
            r_state    <= ST_WRITE;
          end else begin
            r_read_en  <= 1'b1;
            r_wait_cnt <= WAIT_CNT_W'(READ_WAIT);
            r_state    <= ST_READ;
          end
        end
        ST_WRITE: begin
          r_resp_valid <= 1'b1;
          r_state      <= ST_RESP;
        end
        ST_READ: begin
          if (r_wait_cnt == '0) begin
            r_resp_data  <= bus.in_mem_data;
            r_resp_valid <= 1'b1;
            r_state      <= ST_RESP;
          end else begin
            r_wait_cnt <= r_wait_cnt - WAIT_CNT_W'(1);
            r_read_en  <= 1'b1;
          end
        end
        ST_RESP: begin
          if (bus.in_resp_ready) begin
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= ST_IDLE;
          end
        end
        default: begin
          r_resp_valid <= 1'b0;
          r_req_ready  <= 1'b1;
          r_state      <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.out_req_ready         = r_req_ready;
  assign bus.out_resp_valid        = r_resp_valid;
  assign bus.out_resp_data         = r_resp_data;
  assign bus.out_mem_addr          = r_mem_addr;
  assign bus.out_mem_data          = r_mem_data;
  assign bus.out_mem_addr_write_en = r_addr_we;
  assign bus.out_mem_write_en      = r_write_en;
  assign bus.out_mem_read_en       = r_read_en;

endmodule : mem_access_sequencer
`default_nettype wire

// File: tb/tb_mem_access_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_access_sequencer
// Purpose : Self-checking bench for mem_access_sequencer with a small
//           behavioural data_memory_manager attached and a transaction-level
//           reference model (memory array, I/O port values, latency rules).
// Macro   : PORT_ADDR_GUARD_EN - expectations follow the same build option.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_access_sequencer;

  localparam int RW = 1;
`ifdef PORT_ADDR_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  mem_access_sequencer_if #(.ADDR_W(10), .DATA_W(8)) bus ();

  mem_access_sequencer #(
    .ADDR_W    (10),
    .DATA_W    (8),
    .READ_WAIT (RW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural data_memory_manager ----------------
  logic       mgr_clr;
  logic [9:0] mgr_addr;
  logic [7:0] mgr_mem [0:15];
  logic [3:0] mgr_out_port;
  logic [3:0] mgr_in_port;

  always @(posedge clk) begin
    if (mgr_clr) begin
      for (int i = 0; i < 16; i++) mgr_mem[i] <= 8'h00;
      mgr_out_port <= 4'h0;
      mgr_addr     <= 10'h000;
    end else begin
      if (bus.out_mem_addr_write_en) mgr_addr <= bus.out_mem_addr;
      if (bus.out_mem_write_en) begin
        if (mgr_addr == 10'h3FF) mgr_out_port <= bus.out_mem_data[3:0];
        else if (mgr_addr != 10'h3FE) mgr_mem[mgr_addr[3:0]] <= bus.out_mem_data;
      end
    end
  end

  assign bus.in_mem_data = (mgr_addr == 10'h3FE) ? {{4{mgr_in_port[3]}}, mgr_in_port} :
                           (mgr_addr == 10'h3FF) ? {4'h0, mgr_out_port} :
                           mgr_mem[mgr_addr[3:0]];

  // ---------------- transaction-level reference ----------------
  logic [7:0] ref_mem [0:15];
  logic [3:0] ref_out_port;
  logic [9:0] ref_last_addr;
  logic [7:0] ref_last_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Starts and ends at a negedge.
  task automatic do_txn(input logic wr, input logic [9:0] addr, input logic [7:0] data,
                        input int hold);
    logic       rej;
    logic [7:0] exp_data;
    int         exp_lat, lat, n_aw, n_we, n_re, aw1, sum;
    rej      = GUARD && ((wr && addr == 10'h3FE) || (!wr && addr == 10'h3FF));
    exp_data = 8'h00;
    if (!rej && !wr) begin
      if (addr == 10'h3FE)      exp_data = {{4{mgr_in_port[3]}}, mgr_in_port};
      else if (addr == 10'h3FF) exp_data = {4'h0, ref_out_port};
      else                      exp_data = ref_mem[addr[3:0]];
    end
    exp_lat = rej ? 1 : (wr ? 3 : 3 + RW);

    chk("req_ready_idle", {31'd0, bus.out_req_ready}, 1);
    bus.in_req_valid  = 1'b1;
    bus.in_req_write  = wr;
    bus.in_req_addr   = addr;
    bus.in_req_data   = data;
    bus.in_resp_ready = 1'($urandom_range(0, 1)); // must be ignored before valid
    @(posedge clk); #1;
    bus.in_req_valid = 1'b0;
    bus.in_req_addr  = 10'($urandom);
    bus.in_req_data  = 8'($urandom);
    lat = 0; n_aw = 0; n_we = 0; n_re = 0; aw1 = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      sum  = int'(bus.out_mem_addr_write_en) + int'(bus.out_mem_write_en) + int'(bus.out_mem_read_en);
      n_aw += int'(bus.out_mem_addr_write_en);
      n_we += int'(bus.out_mem_write_en);
      n_re += int'(bus.out_mem_read_en);
      if (k == 1) aw1 = int'(bus.out_mem_addr_write_en);
      chk("strobe_onehot", {31'd0, sum <= 1}, 1);
      chk("req_ready_busy", {31'd0, bus.out_req_ready}, 0);
      if (bus.out_resp_valid) begin
        lat = k;
        break;
      end
    end
    bus.in_resp_ready = 1'b0;
    chk("latency", lat, exp_lat);
    if (lat == 0) return;
    chk("addr_we_cycle1", aw1, rej ? 0 : 1);
    chk("n_addr_we", n_aw, rej ? 0 : 1);
    chk("n_write_en", n_we, (rej || !wr) ? 0 : 1);
    chk("n_read_en", n_re, (rej || wr) ? 0 : 1 + RW);

    // Backpressure with a competing request that must be ignored.
    for (int h = 0; h < hold; h++) begin
      bus.in_req_valid = 1'b1;
      bus.in_req_write = 1'($urandom);
      @(negedge clk);
      chk("bp_resp_valid", {31'd0, bus.out_resp_valid}, 1);
      chk("bp_resp_data", {24'd0, bus.out_resp_data}, {24'd0, exp_data});
      chk("bp_req_ready", {31'd0, bus.out_req_ready}, 0);
      chk("bp_no_strobe", {29'd0, bus.out_mem_addr_write_en, bus.out_mem_write_en,
                           bus.out_mem_read_en}, 0);
    end
    bus.in_req_valid = 1'b0;
    chk("resp_data", {24'd0, bus.out_resp_data}, {24'd0, exp_data});
    chk("resp_err", {31'd0, bus.out_resp_err}, {31'd0, rej});
    bus.in_resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_resp_ready = 1'b0;
    @(negedge clk);
    chk("post_resp_valid", {31'd0, bus.out_resp_valid}, 0);
    chk("post_req_ready", {31'd0, bus.out_req_ready}, 1);

    if (!rej) begin
      ref_last_addr = addr;
      ref_last_data = data;
      if (wr) begin
        if (addr == 10'h3FF)      ref_out_port = data[3:0];
        else if (addr != 10'h3FE) ref_mem[addr[3:0]] = data;
      end
    end
    chk("mem_addr_hold", {22'd0, bus.out_mem_addr}, {22'd0, ref_last_addr});
    chk("mem_data_hold", {24'd0, bus.out_mem_data}, {24'd0, ref_last_data});
    chk("out_port", {28'd0, mgr_out_port}, {28'd0, ref_out_port});
  endtask

  initial begin
    logic [4:0] r;
    logic [9:0] a;
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    mgr_clr = 1'b1;
    mgr_in_port = 4'h0;
    bus.in_req_valid = 1'b0;
    bus.in_req_write = 1'b0;
    bus.in_req_addr = '0;
    bus.in_req_data = '0;
    bus.in_resp_ready = 1'b0;
    for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
    ref_out_port  = 4'h0;
    ref_last_addr = 10'h000;
    ref_last_data = 8'h00;

    repeat (3) @(negedge clk);
    chk("rst_req_ready", {31'd0, bus.out_req_ready}, 1);
    chk("rst_resp_valid", {31'd0, bus.out_resp_valid}, 0);
    chk("rst_resp_data", {24'd0, bus.out_resp_data}, 0);
    chk("rst_resp_err", {31'd0, bus.out_resp_err}, 0);
    chk("rst_strobes", {29'd0, bus.out_mem_addr_write_en, bus.out_mem_write_en,
                        bus.out_mem_read_en}, 0);
    chk("rst_mem_addr", {22'd0, bus.out_mem_addr}, 0);
    chk("rst_mem_data", {24'd0, bus.out_mem_data}, 0);
    rst_n = 1'b1;
    mgr_clr = 1'b0;
    @(negedge clk);

    // Directed cases.
    do_txn(1'b1, 10'h00F, 8'h99, 0);
    do_txn(1'b0, 10'h00F, 8'h00, 0);
    mgr_in_port = 4'b1100;
    do_txn(1'b0, 10'h3FE, 8'h00, 0);
    do_txn(1'b1, 10'h00F, 8'h5A, 5);
    do_txn(1'b1, 10'h3FF, 8'h8C, 0);
    do_txn(1'b1, 10'h3FE, 8'h77, 1);
    do_txn(1'b0, 10'h3FF, 8'h00, 2);

    // Asynchronous reset in the middle of a read.
    bus.in_req_valid = 1'b1;
    bus.in_req_write = 1'b0;
    bus.in_req_addr  = 10'h005;
    @(posedge clk); #1;
    bus.in_req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_read_en", {31'd0, bus.out_mem_read_en}, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_strobes", {29'd0, bus.out_mem_addr_write_en, bus.out_mem_write_en,
                         bus.out_mem_read_en}, 0);
    chk("arst_req_ready", {31'd0, bus.out_req_ready}, 1);
    chk("arst_resp_valid", {31'd0, bus.out_resp_valid}, 0);
    chk("arst_mem_addr", {22'd0, bus.out_mem_addr}, 0);
    ref_last_addr = 10'h000;
    ref_last_data = 8'h00;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Randomized traffic over a small address window plus both ports.
    for (int t = 0; t < 60; t++) begin
      r = 5'($urandom_range(0, 19));
      a = (r == 5'd16) ? 10'h3FE : (r == 5'd17) ? 10'h3FF : {6'd0, r[3:0]};
      mgr_in_port = 4'($urandom);
      do_txn(1'($urandom), a, 8'($urandom), int'($urandom_range(0, 4)));
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_mem_access_sequencer
`default_nettype wire
